// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame width and line levels.
// ST_PARITY exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
`ifdef UART_TX_PARITY_EN
    , ST_PARITY
`endif
  } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side write port, status flags and serial line of one UART transmit channel.
interface uart_tx_if #(
  parameter int DIV_W = 16
);
  import uart_pkg::*;

  logic [DIV_W-1:0]          baud_div;
  logic                      wr_en;
  logic [UART_DATA_BITS-1:0] wr_data;
  logic                      full;
  logic                      busy;
  logic                      ovr;
  logic                      tx_done;
  logic                      tx;

  modport master (
    output baud_div, wr_en, wr_data,
    input  full, busy, ovr, tx_done, tx
  );

  modport slave (
    input  baud_div, wr_en, wr_data,
    output full, busy, ovr, tx_done, tx
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the transmitter; DEPTH must be a power of two (>= 2).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [UART_DATA_BITS-1:0] wr_data,
  output logic [UART_DATA_BITS-1:0] rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;

  // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with input FIFO; defining UART_TX_PARITY_EN adds an even-parity bit.
// Frames run back to back while the FIFO has data; all outputs come straight from flops.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);
  localparam int                BIT_W    = $clog2(UART_DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

  logic [UART_DATA_BITS-1:0]     head;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          push;
  logic                          pop;

  uart_state_t                   state;
  logic [DIV_W-1:0]              div_q;
  logic [DIV_W-1:0]              cnt;
  logic [BIT_W-1:0]              bit_cnt;
  logic [UART_DATA_BITS-1:0]     shift;
  logic                          tx_q;
  logic                          done_q;
  logic                          ovr_q;
  logic                          bit_end;
`ifdef UART_TX_PARITY_EN
  logic                          parity_q;
`endif

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (bus.wr_data),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // full is the pre-pop view, so a write into a full FIFO is dropped even if a pop coincides.
  assign push    = bus.wr_en && !fifo_full;
  assign bit_end = (cnt == '0);
  assign pop     = !fifo_empty && ((state == ST_IDLE) || (state == ST_STOP && bit_end));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      div_q    <= '0;
      cnt      <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_q     <= UART_IDLE_LEVEL;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments, so every branch below reads pre-edge state.
      done_q <= 1'b0;
      if (pop) begin
        state    <= ST_START;
        shift    <= head;
        div_q    <= bus.baud_div;
        cnt      <= bus.baud_div;
        tx_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_q <= ^head;
`endif
      end else begin
        case (state)
          ST_IDLE: tx_q <= UART_IDLE_LEVEL;
          default: begin
            if (!bit_end) begin
              cnt <= cnt - DIV_W'(1);
              // tx_done is registered, so raise it on the edge entering the last stop cycle
              if (state == ST_STOP && cnt == DIV_W'(1)) done_q <= 1'b1;
            end else begin
              cnt <= div_q;
              case (state)
                ST_START: begin
                  state   <= ST_DATA;
                  bit_cnt <= '0;
                  tx_q    <= shift[0];
                end
                ST_DATA: begin
                  if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                    state  <= ST_PARITY;
                    tx_q   <= parity_q;
`else
                    state  <= ST_STOP;
                    tx_q   <= 1'b1;
                    done_q <= (div_q == '0);
`endif
                  end else begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    shift   <= shift >> 1;
                    tx_q    <= shift[1];
                  end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                  state  <= ST_STOP;
                  tx_q   <= 1'b1;
                  done_q <= (div_q == '0);
                end
`endif
                default: begin
                  state <= ST_IDLE;
                  tx_q  <= UART_IDLE_LEVEL;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           ovr_q <= 1'b0;
    else if (bus.wr_en && fifo_full)   ovr_q <= 1'b1;
  end

  assign bus.tx      = tx_q;
  assign bus.tx_done = done_q;
  assign bus.ovr     = ovr_q;
  assign bus.full    = fifo_full;
  assign bus.busy    = (state != ST_IDLE) || (fifo_count != '0);
endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-wide UART transmitter (8N1, optional even parity) with a small input FIFO. Sits between the CPU/memory-mapped UART registers and the GPIO pin mux: its serial output drives the GPIO block's `uart_TX0`/`uart_TX1` inputs, one instance per UART channel. It is the transmit counterpart of the pin-muxed receive path.

## Interface
- `FIFO_DEPTH`, 4: entries in the transmit FIFO; power of two, minimum 2.
- `DIV_W`, 16: width of the baud divisor.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `baud_div`  in  DIV_W  clocks per bit minus 1; 0 means 1 clock per bit.
- `wr_en`  in  1  push `wr_data` into the FIFO this cycle.
- `wr_data`  in  8  byte to transmit.
- `full`  out  1  FIFO holds FIFO_DEPTH entries.
- `busy`  out  1  frame in progress or FIFO non-empty.
- `ovr`  out  1  sticky overrun: a write arrived while `full`; cleared only by `rst`.
- `tx_done`  out  1  one-cycle pulse on the last cycle of each stop bit.
- `tx`  out  1  serial line to the GPIO `uart_TXn` input; idles high.

## Operation
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE: `tx`=1. If the FIFO is non-empty: pop the head, latch it into the shift register, latch `baud_div` into the bit-period register, go to START.
- START: `tx`=0 for one bit period.
- DATA: 8 bits, LSB first, one bit period each. A 3-bit bit counter advances at each period end.
- STOP: `tx`=1 for one bit period. `tx_done`=1 on its final cycle. At the end of STOP:
  - FIFO non-empty: pop and go directly to START. There is no idle cycle between frames.
  - FIFO empty: go to IDLE.
- Bit period = latched `baud_div`+1 clocks. It is timed by a DIV_W-bit down-counter reloaded at each bit boundary. Changing `baud_div` mid-frame has no effect until the next frame starts.
- FIFO write with `wr_en`=1 and `full`=1: the byte is dropped, the count is unchanged, and `ovr` is set. This applies even if a pop happens in the same cycle, because `full` is evaluated before the pop.
- Simultaneous push and pop when not full: both take effect and the count is unchanged.
- `busy` = (state ≠ IDLE) or (FIFO count ≠ 0).

## Timing
- Reset values: `tx`=1, `full`=0, `busy`=0, `ovr`=0, `tx_done`=0. FSM is in IDLE and the FIFO is empty.
- Asserting `rst` mid-frame forces `tx` high immediately (asynchronously) and discards the FIFO contents.
- Latency: `wr_en` sampled at edge E into an empty FIFO with the FSM in IDLE → `busy`=1 after E. The FSM pops at E+1, and `tx` falls after E+1.
- Frame length: 10 bit periods (11 with parity) = 10×(`baud_div`+1) clocks.
- `tx` and all status outputs are registered; there are no combinational paths from input to output.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is inserted between DATA and STOP.
  - `tx` = XOR of the 8 data bits (even parity) for one bit period.
  - Frame is 11 bit periods.
- Macro undefined: no PARITY state, no parity logic, 10-bit 8N1 frame.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum.
  - `UART_DATA_BITS`=8.
  - Idle line level constant.
- The package is shared with the future `uart_rx`.
- Sub-module `uart_tx_fifo`: synchronous FIFO with push, pop, head data, `full`, `empty`, and count. It reuses FIFO_DEPTH.
- The top level holds the FSM, the baud counter, the bit counter, the shift register, and the `ovr` flag.

## Test plan
- Reset check: after `rst` → `tx`=1, `full`=0, `busy`=0, `ovr`=0, `tx_done`=0.
- Single byte: `baud_div`=3, write 0xA5 → `tx` shows 0,1,0,1,0,0,1,0,1,1, each level held for 4 clocks (40 clocks total). `tx_done` pulses once, on the 40th clock. `busy` falls on the following cycle.
- Back-to-back: `baud_div`=0, write 0x00 then 0xFF on consecutive cycles → 20 contiguous bit cycles: 0, eight 0s, 1, 0, eight 1s, 1. No idle gap between frames.
- Overflow: `baud_div`=100, five writes 0x11..0x15 on consecutive cycles with depth 4:
  - The first write is popped on the next cycle, so 0x11–0x15 are all accepted.
  - A sixth write (0x16) on the next cycle is dropped and sets `ovr`=1.
  - Exactly five frames are transmitted.
- Mid-frame reset and divisor change:
  - Change `baud_div` 3→7 during a frame → the current frame keeps 4-clock bits and the next frame uses 8-clock bits.
  - Assert `rst` during DATA → `tx`=1 immediately, the FIFO is empty, and no further `tx_done` pulses occur.
- Parity (with `UART_TX_PARITY_EN`), `baud_div`=1:
  - Write 0x07 → parity bit 1 (three ones), frame 22 clocks.
  - Write 0xA5 → parity bit 0.
